// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store per
// handshake, performs the word access after LATENCY cycles and returns a one-cycle response.
module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("data_mem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic        cap_write;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic        accept;
   logic        enter_resp;

   logic        acc_write;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_err;
   logic [IDX_W-1:0] acc_idx;

   logic [31:0] mem [DEPTH];

   always_comb begin
      next_state = state;
      req_ready  = 1'b1;
      busy       = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            accept = req_valid;
         end
         WAIT: begin
            req_ready = 1'b0;
            busy      = 1'b1;
            if (cnt == 4'd1) begin
               next_state = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            accept     = req_valid;
            if (!req_valid) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (accept) begin
         if (LATENCY == 1) begin
            next_state = RESP;
            enter_resp = 1'b1;
         end else begin
            next_state = WAIT;
         end
      end
   end

   // With single-cycle latency the access happens at the acceptance edge, so the live
   // request is used; otherwise the captured copy is.
   always_comb begin
      acc_write = (LATENCY == 1) ? req_write : cap_write;
      acc_addr  = (LATENCY == 1) ? req_addr  : cap_addr;
      acc_wdata = (LATENCY == 1) ? req_wdata : cap_wdata;
      acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
      acc_idx   = acc_addr[IDX_W+1:2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         cap_write  <= 1'b0;
         cap_addr   <= 32'd0;
         cap_wdata  <= 32'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            cnt       <= LAT_M1;
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err   <= acc_err;
            resp_rdata <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'd0;
         end else begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
         end
      end
   end

   // Stores commit at the edge entering RESP; a reset held at that edge discards them.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && acc_write && !acc_err) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule
